// File: rtl/lstm_gate_sequencer.sv
// lstm_gate_sequencer: walks one LSTM sequence (timestep -> hidden unit ->
// gate -> operand phase -> chunk). It issues one chunk-read request per
// PARALL_NUM-wide slice to the weight reader, then hands each finished hidden
// unit to the C/H update stage.
//
// Handshakes:
//   rd_start/rd_done: rd_start is a one-cycle request. The FSM then waits in
//     WAIT for a one-cycle rd_done. rd_done seen in any other state is ignored.
//   cell_req/cell_ack: cell_req is a level that stays high until cell_ack is
//     sampled high in CELL. cell_ack seen in any other state is ignored.
module lstm_gate_sequencer #(
  parameter int input_size      = 16,
  parameter int hidden_size     = 8,
  parameter int sequence_length = 2,
  parameter int PARALL_NUM      = 8,
  localparam int LW = $clog2(PARALL_NUM) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [2:0]    STATE,
  output logic [2:0]    STATE_TYPE,
  output logic          rd_start,
  output logic [23:0]   chunk_base,
  output logic [LW-1:0] chunk_len,
  output logic          last_chunk,
  input  logic          rd_done,
  output logic [23:0]   hid_idx,
  output logic [23:0]   step_idx,
  output logic          cell_req,
  input  logic          cell_ack,
  output logic          HID_CYCLE_FINISH,
  output logic [2:0]    fsm_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_NEXT  = 3'd3,
    S_CELL  = 3'd4,
    S_DONE  = 3'd5
  } fsm_t;

  localparam logic [2:0]  G_IN      = 3'd1;
  localparam logic [2:0]  G_OUT     = 3'd4;
  localparam logic [2:0]  PH_AD     = 3'd1;
  localparam logic [2:0]  PH_AH     = 3'd2;
  localparam logic [23:0] LAST_HID  = 24'(hidden_size - 1);
  localparam logic [23:0] LAST_STEP = 24'(sequence_length - 1);

  fsm_t        state;
  logic [2:0]  nx_gate;
  logic [2:0]  nx_phase;
  logic [23:0] nx_base;
  logic        nx_cell;

  assign fsm_state = state;

  // Row length of the operand being read: input features or hidden units.
  function automatic logic [23:0] row_len(input logic [2:0] ph);
    return (ph == PH_AD) ? 24'(input_size) : 24'(hidden_size);
  endfunction

  // A chunk is the last one of its phase when it reaches the end of the row.
  function automatic logic is_last(input logic [2:0] ph, input logic [23:0] base);
    return (25'(base) + 25'(PARALL_NUM)) >= 25'(row_len(ph));
  endfunction

  // The last chunk carries the remainder (1..PARALL_NUM); all others are full.
  function automatic logic [LW-1:0] len_of(input logic [2:0] ph, input logic [23:0] base);
    logic [23:0] rem;
    rem = row_len(ph) - base;
    if (is_last(ph, base)) return LW'(rem);
    else return LW'(PARALL_NUM);
  endfunction

  // Next read target after a chunk completes: chunk, then phase, then gate carry.
  always_comb begin
    nx_gate  = STATE;
    nx_phase = STATE_TYPE;
    nx_base  = chunk_base + 24'(PARALL_NUM);
    nx_cell  = 1'b0;
    if (last_chunk) begin
      nx_base = '0;
      if (STATE_TYPE == PH_AD) begin
        nx_phase = PH_AH;
      end else if (STATE < G_OUT) begin
        nx_gate  = STATE + 3'd1;
        nx_phase = PH_AD;
      end else begin
        nx_cell = 1'b1;
      end
    end
  end

  // Sequencer FSM; every output is registered and set on entry to its state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= S_IDLE;
      busy             <= 1'b0;
      done             <= 1'b0;
      STATE            <= '0;
      STATE_TYPE       <= '0;
      rd_start         <= 1'b0;
      chunk_base       <= '0;
      chunk_len        <= LW'(PARALL_NUM);
      last_chunk       <= 1'b0;
      hid_idx          <= '0;
      step_idx         <= '0;
      cell_req         <= 1'b0;
      HID_CYCLE_FINISH <= 1'b0;
    end else begin
      rd_start         <= 1'b0;
      done             <= 1'b0;
      HID_CYCLE_FINISH <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state      <= S_ISSUE;
            busy       <= 1'b1;
            rd_start   <= 1'b1;
            step_idx   <= '0;
            hid_idx    <= '0;
            STATE      <= G_IN;
            STATE_TYPE <= PH_AD;
            chunk_base <= '0;
            chunk_len  <= len_of(PH_AD, '0);
            last_chunk <= is_last(PH_AD, '0);
          end
        end
        S_ISSUE: state <= S_WAIT;
        S_WAIT: begin
          if (rd_done) state <= S_NEXT;
        end
        S_NEXT: begin
          if (nx_cell) begin
            state      <= S_CELL;
            cell_req   <= 1'b1;
            STATE      <= G_OUT;
            STATE_TYPE <= '0;
            last_chunk <= 1'b0;
          end else begin
            state      <= S_ISSUE;
            rd_start   <= 1'b1;
            STATE      <= nx_gate;
            STATE_TYPE <= nx_phase;
            chunk_base <= nx_base;
            chunk_len  <= len_of(nx_phase, nx_base);
            last_chunk <= is_last(nx_phase, nx_base);
          end
        end
        S_CELL: begin
          if (cell_ack) begin
            cell_req <= 1'b0;
            if (hid_idx < LAST_HID || step_idx < LAST_STEP) begin
              if (hid_idx < LAST_HID) begin
                hid_idx <= hid_idx + 24'd1;
              end else begin
                hid_idx          <= '0;
                step_idx         <= step_idx + 24'd1;
                HID_CYCLE_FINISH <= 1'b1;
              end
              state      <= S_ISSUE;
              rd_start   <= 1'b1;
              STATE      <= G_IN;
              STATE_TYPE <= PH_AD;
              chunk_base <= '0;
              chunk_len  <= len_of(PH_AD, '0);
              last_chunk <= is_last(PH_AD, '0);
            end else begin
              state            <= S_DONE;
              HID_CYCLE_FINISH <= 1'b1;
              hid_idx          <= '0;
              step_idx         <= '0;
              STATE            <= '0;
              STATE_TYPE       <= '0;
              chunk_base       <= '0;
              chunk_len        <= LW'(PARALL_NUM);
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b1;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
